// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 keystream core.
package rc4_pkg;
   localparam int SBOX_SIZE = 256;
   typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, DONE} state_t;
   typedef enum logic [1:0] {PH_A, PH_B, PH_C} phase_t;
   typedef enum logic [1:0] {WR_NONE, WR_INIT, WR_SWAP} wr_mode_t;
endpackage

// File: rtl/rc4_new_design_if.sv
// rc4_new_design_if: request/result bundle between a caller and the RC4 core.
interface rc4_new_design_if #(parameter int NUMS_OF_BYTES = 16);
   logic                       start;
   logic [NUMS_OF_BYTES*8-1:0] key;
   logic [7:0]                 key_length;
   logic [NUMS_OF_BYTES*8-1:0] ckey;
   logic                       done;
   modport master (output start, key, key_length, input ckey, done);
   modport slave (input start, key, key_length, output ckey, done);
endinterface

// File: rtl/rc4_sbox.sv
// rc4_sbox: 256-byte RC4 state with two read ports, identity fill and a one-cycle swap.
module rc4_sbox
   import rc4_pkg::*;
(
   input  logic     clk,
   input  wr_mode_t i_mode,
   input  logic [7:0] i_addr_a,
   input  logic [7:0] i_addr_b,
   input  logic [7:0] i_addr_t,
   output logic [7:0] o_data_a,
   output logic [7:0] o_data_b,
   output logic [7:0] o_post
);
   logic [7:0] r_s [SBOX_SIZE];
   assign o_data_a = r_s[i_addr_a];
   assign o_data_b = r_s[i_addr_b];
   // o_post reads address t as it will look once a and b have been swapped
   assign o_post = (i_addr_t == i_addr_a) ? o_data_b :
                   (i_addr_t == i_addr_b) ? o_data_a : r_s[i_addr_t];
   always_ff @(posedge clk) begin
      if (i_mode == WR_INIT) r_s[i_addr_a] <= i_addr_a;
      else if (i_mode == WR_SWAP) begin
         r_s[i_addr_a] <= o_data_b;
         r_s[i_addr_b] <= o_data_a;
      end
   end
endmodule

// File: rtl/rc4_new_design.sv
// rc4_new_design: RC4 control FSM; fills and key-schedules the S-box, then emits
// NUMS_OF_BYTES keystream bytes in parallel on ckey with a done flag.
module rc4_new_design
   import rc4_pkg::*;
#(
   parameter int NUMS_OF_BYTES = 16
) (
   input logic clk,
   input logic rst_n,
   rc4_new_design_if.slave bus
);
   localparam int NB = NUMS_OF_BYTES * 8;
   localparam logic [7:0] LAST = 8'(NUMS_OF_BYTES - 1);
   state_t r_state, w_state;
   phase_t r_phase, w_phase;
   logic [7:0] r_i, w_i, r_j, w_j, r_kidx, w_kidx, r_out, w_out, r_len, w_len;
   logic [NB-1:0] r_ckey, w_ckey;
   logic r_done, w_done;
   logic [7:0] w_si, w_sj, w_post, w_key_byte, w_len_eff;
   wr_mode_t w_mode;
   rc4_sbox u_sbox (
      .clk(clk), .i_mode(w_mode), .i_addr_a(r_i), .i_addr_b(r_j),
      .i_addr_t(w_si + w_sj), .o_data_a(w_si), .o_data_b(w_sj), .o_post(w_post)
   );
   assign w_len_eff = (bus.key_length == 8'd0 || bus.key_length > 8'(NUMS_OF_BYTES)) ?
                      8'(NUMS_OF_BYTES) : bus.key_length;
   assign bus.ckey = r_ckey;
   assign bus.done = r_done;
   always_comb begin
      w_key_byte = '0;
      for (int k = 0; k < NUMS_OF_BYTES; k++)
         if (r_kidx == 8'(k)) w_key_byte = bus.key[k*8 +: 8];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_phase <= PH_A;
         r_i     <= '0;
         r_j     <= '0;
         r_kidx  <= '0;
         r_out   <= '0;
         r_len   <= '0;
         r_ckey  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_phase <= w_phase;
         r_i     <= w_i;
         r_j     <= w_j;
         r_kidx  <= w_kidx;
         r_out   <= w_out;
         r_len   <= w_len;
         r_ckey  <= w_ckey;
         r_done  <= w_done;
      end
   end
   always_comb begin
      w_state = r_state;
      w_phase = r_phase;
      w_i     = r_i;
      w_j     = r_j;
      w_kidx  = r_kidx;
      w_out   = r_out;
      w_len   = r_len;
      w_ckey  = r_ckey;
      w_done  = r_done;
      w_mode  = WR_NONE;
      case (r_state)
         IDLE: begin
            w_done = 1'b0;
            if (bus.start) begin
               w_state = INIT;
               w_i     = '0;
               w_j     = '0;
               w_kidx  = '0;
               w_ckey  = '0;
               w_len   = w_len_eff;
            end
         end
         INIT: begin
            w_mode = WR_INIT;
            w_i    = r_i + 8'd1;
            if (r_i == 8'hff) begin
               w_state = KSA;
               w_phase = PH_A;
            end
         end
         KSA: begin
            if (r_phase == PH_A) begin
               w_j     = r_j + w_si + w_key_byte;
               w_phase = PH_B;
            end else begin
               w_mode  = WR_SWAP;
               w_i     = r_i + 8'd1;
               w_kidx  = (r_kidx == r_len - 8'd1) ? 8'd0 : r_kidx + 8'd1;
               w_phase = PH_A;
               if (r_i == 8'hff) begin
                  w_state = PRGA;
                  w_j     = '0;
                  w_out   = '0;
               end
            end
         end
         PRGA: begin
            if (r_phase == PH_A) begin
               w_i     = r_i + 8'd1;
               w_phase = PH_B;
            end else if (r_phase == PH_B) begin
               w_j     = r_j + w_si;
               w_phase = PH_C;
            end else begin
               w_mode  = WR_SWAP;
               w_phase = PH_A;
               w_out   = r_out + 8'd1;
               for (int k = 0; k < NUMS_OF_BYTES; k++)
                  if (r_out == 8'(k)) w_ckey[k*8 +: 8] = w_post;
               if (r_out == LAST) begin
                  w_state = DONE;
                  w_done  = 1'b1;
               end
            end
         end
         DONE: begin
            w_done = bus.start;
            if (!bus.start) w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end
endmodule

// File: tb/tb_rc4_new_design.sv
// tb_rc4_new_design: directed vectors for the RC4 core, checked against
// published keystreams and a plain behavioural RC4 model.
module tb_rc4_new_design;
   localparam int N = 16;
   localparam int LAT = 768 + 3 * N;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_assert = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   rc4_new_design_if #(.NUMS_OF_BYTES(N)) bus ();
   rc4_new_design #(.NUMS_OF_BYTES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [127:0] key;
      logic [7:0]   len;
      int           mlen;
      int           nknown;
      logic [127:0] known;
   } vec_t;
   vec_t vecs[6];

   function automatic logic [127:0] rev(input logic [127:0] x);
      logic [127:0] r;
      for (int n = 0; n < 16; n++) r[n*8 +: 8] = x[(15-n)*8 +: 8];
      return r;
   endfunction

   function automatic logic [127:0] rc4_model(input logic [127:0] k, input int len);
      logic [7:0] s[256];
      logic [7:0] t;
      logic [127:0] r;
      int i, j;
      for (int a = 0; a < 256; a++) s[a] = 8'(a);
      j = 0;
      for (int a = 0; a < 256; a++) begin
         j = (j + int'(s[a]) + int'(k[(a % len)*8 +: 8])) % 256;
         t = s[a]; s[a] = s[j]; s[j] = t;
      end
      i = 0; j = 0; r = '0;
      for (int n = 0; n < N; n++) begin
         i = (i + 1) % 256;
         j = (j + int'(s[i])) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         r[n*8 +: 8] = s[(int'(s[i]) + int'(s[j])) % 256];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run(input logic [127:0] key_le, input logic [7:0] len, output int edges);
      int c;
      @(negedge clk);
      bus.key = key_le;
      bus.key_length = len;
      bus.start = 1'b1;
      c = 0;
      edges = -1;
      while (c < 2000) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            edges = c;
            break;
         end
         c++;
      end
   endtask

   task automatic drop_start();
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int edges;
      logic [127:0] exp, mask, held;
      int bad_done, bad_ckey;
      vecs[0] = '{128'h01020304050000000000000000000000, 8'd5, 5, 16, 128'hb2396305f03dc027ccc3524a0a1118a8};
      vecs[1] = '{128'h57696B69000000000000000000000000, 8'd4, 4, 5, 128'h6044DB6D410000000000000000000000};
      vecs[2] = '{128'h4B657900000000000000000000000000, 8'd3, 3, 9, 128'hEB9F7781B734CA72A700000000000000};
      vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 8'd0, 16, 0, 128'h0};
      vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f, 8'd200, 16, 0, 128'h0};
      vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 8'd16, 16, 0, 128'h0};
      bus.start = 1'b0;
      bus.key = '0;
      bus.key_length = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_done", {127'b0, bus.done}, 128'h0);
      check("reset_ckey", bus.ckey, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int v = 0; v < 6; v++) begin
         exp = rc4_model(rev(vecs[v].key), vecs[v].mlen);
         mask = '0;
         for (int n = 0; n < vecs[v].nknown; n++) mask[n*8 +: 8] = 8'hff;
         run(rev(vecs[v].key), vecs[v].len, edges);
         check($sformatf("latency_v%0d", v), 128'(edges), 128'(LAT));
         check($sformatf("known_v%0d", v), bus.ckey & mask, rev(vecs[v].known) & mask);
         check($sformatf("model_v%0d", v), bus.ckey, exp);
         drop_start();
         check($sformatf("done_low_v%0d", v), {127'b0, bus.done}, 128'h0);
         check($sformatf("ckey_held_v%0d", v), bus.ckey, exp);
      end
      // Hold start high after completion: no retrigger, stable result
      exp = rc4_model(rev(vecs[0].key), 5);
      run(rev(vecs[0].key), 8'd5, edges);
      held = bus.ckey;
      bad_done = 0;
      bad_ckey = 0;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk);
         #1;
         if (bus.done !== 1'b1) bad_done++;
         if (bus.ckey !== exp) bad_ckey++;
      end
      check("hold_done_drops", 128'(bad_done), 128'h0);
      check("hold_ckey_changes", 128'(bad_ckey), 128'h0);
      check("hold_ckey_first", held, exp);
      drop_start();
      // Asynchronous reset in the middle of KSA
      @(negedge clk);
      bus.key = rev(vecs[2].key);
      bus.key_length = 8'd3;
      bus.start = 1'b1;
      repeat (400) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_done", {127'b0, bus.done}, 128'h0);
      check("midreset_ckey", bus.ckey, 128'h0);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp = rc4_model(rev(vecs[2].key), 3);
      run(rev(vecs[2].key), 8'd3, edges);
      check("rerun_latency", 128'(edges), 128'(LAT));
      check("rerun_ckey", bus.ckey, exp);
      check("rerun_known", bus.ckey & 128'h000000000000000000ffffffffffffff,
            rev(vecs[2].known) & 128'h000000000000000000ffffffffffffff);
      drop_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/rc4_new_design.md
Name: rc4_new_design

Overview:
- RC4 keystream generator.
- Loads a variable-length key (1..NUMS_OF_BYTES bytes).
- Runs the key-scheduling algorithm (KSA) over an internal 256-byte S-box.
- Runs the pseudo-random generation algorithm (PRGA) to produce NUMS_OF_BYTES keystream bytes, presented in parallel on ckey with a done flag.
- Standalone crypto core; the caller XORs ckey with data.

Parameters:
- NUMS_OF_BYTES, 16: maximum key length in bytes, and the number of keystream bytes produced per run (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level request; sampled only in IDLE.
- key  in  NUMS_OF_BYTES*8  key bytes; byte n (0-based) at key[n*8 +: 8]; byte 0 is first.
- key_length  in  8  number of valid key bytes.
- ckey  out  NUMS_OF_BYTES*8  keystream; keystream byte n at ckey[n*8 +: 8]; byte 0 is first generated.
- done  out  1  high while ckey holds a complete result.

Behaviour:
- Storage and registers:
  - S-box: 256x8 register array, internal; combinational reads.
  - Registers: state, i (8b), j (8b), kidx (key index), out counter, ckey, done.
  - All index and j arithmetic is mod 256 (natural 8-bit wrap).
- Reset: state=IDLE; i=j=kidx=0; ckey=0; done=0. S contents are don't-care. Reset mid-run aborts immediately to these values.
- Key length resolution: key_length is captured on leaving IDLE, as effective length L.
  - key_length=0 or >NUMS_OF_BYTES gives L=NUMS_OF_BYTES.
  - key and key_length must remain stable through KSA.
- IDLE:
  - done=0.
  - start=1 → INIT: i=0, j=0, kidx=0, ckey cleared.
- INIT, 256 cycles: each cycle S[i]=i, i++. After i=255 → KSA with i=0.
- KSA, 2 cycles per iteration, 256 iterations (512 cycles):
  - cycle A: j = j + S[i] + key[kidx].
  - cycle B: swap S[i] and S[j]; i++; kidx = (kidx==L-1) ? 0 : kidx+1, so no divider is needed.
  - After the iteration with i=255 → PRGA with i=0, j=0, out counter=0.
- PRGA, 3 cycles per byte:
  - cycle A: i = i+1.
  - cycle B: j = j + S[i].
  - cycle C: swap S[i] and S[j], and write ckey byte[out] = S'[(S[i]+S[j]) mod 256].
    - S' is the post-swap view, taken combinationally: t==i gives old S[j]; t==j gives old S[i]; otherwise S[t].
  - out++. After byte NUMS_OF_BYTES-1 → DONE.
- DONE:
  - done=1; ckey holds all bytes, stable.
  - Stays while start=1 (no retrigger while start is held).
  - start=0 → IDLE, which clears done. ckey is held until the next start.
- Latency:
  - Edge 0 is the edge on which IDLE samples start=1.
  - done rises at edge 768+3*NUMS_OF_BYTES (816 for the default).
  - done rises with ckey already final, so the rising edge of done is a valid capture point.
- start changes during INIT, KSA or PRGA are ignored.

Decomposition:
- Shared package rc4_pkg:
  - state enum: IDLE, INIT, KSA, PRGA, DONE.
  - SBOX_SIZE=256.
  - KSA/PRGA sub-phase encodings.
- One sub-module is natural: rc4_sbox.
  - 256x8 register array, two combinational read ports.
  - Write modes: init-write (S[a]=a) and single-cycle swap of two addresses.
  - The control FSM stays in rc4_new_design.

Test Plan:
- Reset, then key=01 02 03 04 05, key_length=5, start=1 → done at edge 816; ckey bytes 0..15 = b2 39 63 05 f0 3d c0 27 cc c3 52 4a 0a 11 18 a8.
- key="Key" (4B 65 79), key_length=3 → ckey bytes 0..8 = EB 9F 77 81 B7 34 CA 72 A7.
- key="Wiki" (57 69 6B 69), key_length=4 → bytes 0..4 = 60 44 DB 6D 41. Then drop start → done=0, IDLE. Reassert start with the "Key" vector → correct "Key" keystream; no state leakage between runs.
- key_length=0, and separately key_length=200 → result identical to a key_length=16 run with the same key.
- Hold start=1 after done → done stays 1 and ckey is unchanged for 1000 cycles.
- Assert rst_n=0 during KSA (about edge 400) → done=0 and ckey=0 immediately. Release and restart → correct result at edge 816 after the new start.
